// File: rtl/sram_pkg.sv
// Shared types and helpers for the accumulating SRAM.
// sat_add is only referenced when SRAM_ACC_SAT_EN is defined.
package sram_pkg;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_RD,
    OP_WR,
    OP_ACC
  } sram_op_e;

  localparam int SAT_W = 64;

  // Operands arrive sign-extended to SAT_W; the clamp uses the real width dw.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int unsigned      dw
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s  = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    hi = (65'sd1 <<< (dw - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (dw - 1));
    if (s > hi) begin
      sat_add = hi[SAT_W-1:0];
    end else if (s < lo) begin
      sat_add = lo[SAT_W-1:0];
    end else begin
      sat_add = s[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sram_acc_alu.sv
// Accumulate adder: wraps by default, saturates when
// SRAM_ACC_SAT_EN is defined.
module sram_acc_alu
  import sram_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

`ifdef SRAM_ACC_SAT_EN
  logic [SAT_W-1:0] r;

  assign r = sat_add(SAT_W'($signed(a)),
                     SAT_W'($signed(b)),
                     DW);
  assign y = r[DW-1:0];
`else
  assign y = a + b;
`endif

endmodule

// File: rtl/sram_acc_param.sv
// Single-port SRAM with in-place accumulate and a forwarded commit stage.
// ACC overflow saturates when SRAM_ACC_SAT_EN is defined, else wraps.
module sram_acc_param
  import sram_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          ACC,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  output logic          Q_VALID
);

  logic [DW-1:0] mem [DEPTH-1:0];

  logic          s2_v;
  logic [AW-1:0] s2_a;
  logic [DW-1:0] s2_d;

  logic [31:0]   a_ext;
  logic          in_rng;
  logic          nop;
  sram_op_e      op;
  logic [DW-1:0] fwd;
  logic [DW-1:0] acc_y;

  assign a_ext  = 32'(A);
  assign in_rng = a_ext < 32'(DEPTH);
  assign nop    = CEN | ~in_rng;

  always_comb begin
    op = OP_NOP;
    unique case (1'b1)
      nop:                  op = OP_NOP;
      !nop && WEN:          op = OP_RD;
      !nop && !WEN && !ACC: op = OP_WR;
      !nop && !WEN && ACC:  op = OP_ACC;
    endcase
  end

  // In-flight write is the newest value for its address.
  assign fwd = (s2_v && s2_a == A) ? s2_d : mem[A];

  sram_acc_alu #(
    .DW (DW)
  ) u_alu (
    .a (fwd),
    .b (D),
    .y (acc_y)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      Q       <= '0;
      Q_VALID <= 1'b0;
      s2_v    <= 1'b0;
      s2_a    <= '0;
      s2_d    <= '0;
    end else begin
      Q_VALID <= 1'b0;
      s2_v    <= 1'b0;
      unique case (op)
        OP_RD: begin
          Q       <= fwd;
          Q_VALID <= 1'b1;
        end
        OP_WR: begin
          s2_v <= 1'b1;
          s2_a <= A;
          s2_d <= D;
        end
        OP_ACC: begin
          s2_v <= 1'b1;
          s2_a <= A;
          s2_d <= acc_y;
        end
        default: ;
      endcase
    end
  end

  // Reset clears s2_v asynchronously, so a pending write is dropped.
  always_ff @(posedge CLK) begin
    if (s2_v) begin
      mem[s2_a] <= s2_d;
    end
  end

endmodule

// File: tb/tb_sram_acc_param.sv
// Directed scoreboard bench for sram_acc_param (DEPTH 2048 and 1000).
// Expected ACC results follow SRAM_ACC_SAT_EN when defined.
module tb_sram_acc_param;
  import sram_pkg::*;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          CEN;
  logic          WEN;
  logic          ACC;
  logic [10:0]   A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          Q_VALID;
  logic [DW-1:0] Q2;
  logic          Q_VALID2;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [31:0]   mdl [int];
  logic [31:0]   sb [$];
  logic [31:0]   last_q;

  sram_acc_param #(.DW(DW), .DEPTH(2048)) u_dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .CEN     (CEN),
    .WEN     (WEN),
    .ACC     (ACC),
    .A       (A),
    .D       (D),
    .Q       (Q),
    .Q_VALID (Q_VALID)
  );

  sram_acc_param #(.DW(DW), .DEPTH(1000)) u_dut2 (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .CEN     (CEN),
    .WEN     (WEN),
    .ACC     (ACC),
    .A       (A[9:0]),
    .D       (D),
    .Q       (Q2),
    .Q_VALID (Q_VALID2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] acc_ref(input logic [31:0] a,
                                          input logic [31:0] b);
`ifdef SRAM_ACC_SAT_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
`else
    return a + b;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input sram_op_e op, input int a,
                      input logic [31:0] d, input string tag);
    logic [31:0] e;
    @(negedge CLK);
    CEN = (op == OP_NOP);
    WEN = (op == OP_RD);
    ACC = (op == OP_ACC);
    A   = 11'(a);
    D   = d;
    case (op)
      OP_WR:  mdl[a] = d;
      OP_ACC: mdl[a] = acc_ref(mdl[a], d);
      OP_RD:  sb.push_back(mdl.exists(a) ? mdl[a] : 32'hx);
      default: ;
    endcase
    @(posedge CLK);
    #1;
    if (op == OP_RD) begin
      chk({tag, "_qv"}, 32'(Q_VALID), 32'd1);
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk(tag, Q, e);
        last_q = e;
      end
    end else begin
      chk({tag, "_qv0"}, 32'(Q_VALID), 32'd0);
      chk({tag, "_hold"}, Q, last_q);
    end
    CEN = 1'b1;
  endtask

  initial begin
    RSTN   = 1'b0;
    CEN    = 1'b1;
    WEN    = 1'b1;
    ACC    = 1'b0;
    A      = '0;
    D      = '0;
    last_q = '0;
    #12;
    chk("rst_q", Q, 32'h0);
    chk("rst_qv", 32'(Q_VALID), 32'd0);
    chk("rst_q2", Q2, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;

    step(OP_WR,  5, 32'h1234, "t1_wr");
    step(OP_RD,  5, 32'h0,    "t1_rd_fwd");
    step(OP_NOP, 0, 32'h0,    "t1_nop");
    step(OP_NOP, 0, 32'h0,    "t1_nop");
    step(OP_NOP, 0, 32'h0,    "t1_nop");
    step(OP_RD,  5, 32'h0,    "t1_rd_arr");

    step(OP_WR,  7, 32'd10,   "t2_wr");
    for (int i = 0; i < 4; i++) begin
      step(OP_ACC, 7, 32'd3,  "t2_acc");
    end
    step(OP_RD,  7, 32'h0,    "t2_rd");

    step(OP_WR,  9, 32'h7FFFFFFF, "t3_wr_pos");
    step(OP_ACC, 9, 32'h1,        "t3_acc_pos");
    step(OP_RD,  9, 32'h0,        "t3_rd_pos");
    step(OP_WR,  9, 32'h80000000, "t3_wr_neg");
    step(OP_ACC, 9, 32'hFFFFFFFF, "t3_acc_neg");
    step(OP_RD,  9, 32'h0,        "t3_rd_neg");

    step(OP_WR,  3, 32'd1,   "t4_wr3");
    step(OP_WR,  4, 32'd44,  "t4_wr4");
    step(OP_ACC, 3, 32'd4,   "t4_acc3");
    step(OP_RD,  4, 32'h0,   "t4_rd4");
    step(OP_RD,  3, 32'h0,   "t4_rd3");
    step(OP_ACC, 3, 32'd4,   "t4_acc3b");
    step(OP_WR,  3, 32'd100, "t4_wr3b");
    step(OP_RD,  3, 32'h0,   "t4_rd3b");
    step(OP_RD,  4, 32'h0,   "t4_rd4b");

    step(OP_WR, 11, 32'h55, "t5_wr");
    step(OP_RD, 11, 32'h0,  "t5_rd");
    step(OP_WR, 11, 32'hAA, "t5_wr_drop");
    #2;
    RSTN = 1'b0;
    #1;
    chk("t5_rst_q", Q, 32'h0);
    chk("t5_rst_qv", 32'(Q_VALID), 32'd0);
    chk("t5_rst_q2", Q2, 32'h0);
    last_q   = '0;
    mdl[11]  = 32'h55;
    CEN      = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    step(OP_RD, 11, 32'h0, "t5_rd_after");

    step(OP_WR, 5, 32'd77, "t6_wr5");
    step(OP_RD, 5, 32'h0,  "t6_rd5");
    chk("t6_d2_rd5", Q2, 32'd77);
    chk("t6_d2_rd5_qv", 32'(Q_VALID2), 32'd1);
    step(OP_WR, 1000, 32'd1, "t6_wr1000");
    step(OP_RD, 1000, 32'h0, "t6_rd1000");
    chk("t6_d2_rd1000_qv", 32'(Q_VALID2), 32'd0);
    chk("t6_d2_rd1000_q", Q2, 32'd77);
    step(OP_NOP, 5, 32'd999, "t6_cen_hi");
    step(OP_RD,  5, 32'h0,   "t6_rd5b");
    chk("t6_d2_rd5b", Q2, 32'd77);
    chk("t6_d2_rd5b_qv", 32'(Q_VALID2), 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
